// File: rtl/tpiu_frame_decode.sv
// rtl/tpiu_frame_decode.sv - TPIU 16-byte frame decoder to an ID-tagged byte stream
//
// Purpose: captures TPIU frames announced by an asynchronous toggle, holds
// one working and one pending frame, and emits the data bytes one slot per
// clock. Each byte is tagged with the trace source ID in force for that slot.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   PkAvail    frame-ready toggle, asynchronous to clk
//   Packet     last complete frame, byte k = Packet[8k+7:8k]
//   byteValid  output byte valid
//   byteReady  downstream accepts when byteValid && byteReady
//   byteOut    decoded data byte
//   byteId     trace source ID of byteOut
//   dropCount  frames dropped for lack of buffer space, saturating
module tpiu_frame_decode #(
  parameter int DROPW = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             PkAvail,
  input  logic [127:0]     Packet,
  output logic             byteValid,
  input  logic             byteReady,
  output logic [7:0]       byteOut,
  output logic [6:0]       byteId,
  output logic [DROPW-1:0] dropCount
);

  typedef enum logic {S_IDLE, S_DECODE} state_e;

  state_e           state_q;
  logic [3:0]       slot_q;
  logic             sync1_q, sync2_q, hist_q;
  logic [127:0]     work_q, pend_q;
  logic             pend_v_q;
  logic [6:0]       cur_id_q, dly_id_q;
  logic             dly_v_q;
  logic             valid_q;
  logic [7:0]       out_q;
  logic [6:0]       id_q;
  logic [DROPW-1:0] drop_q;

  logic       frame_evt, stall, pend_take;
  logic [7:0] slot_byte, aux;
  logic       aux_bit, is_even, is_idchg, last_slot;
  logic       emit_d;
  logic [7:0] data_d;
  logic [6:0] eff_id_d;

  always_comb begin
    frame_evt = sync2_q ^ hist_q;
    stall     = valid_q && !byteReady;
    slot_byte = work_q[{slot_q, 3'b000} +: 8];
    aux       = work_q[127:120];
    aux_bit   = aux[slot_q[3:1]];
    is_even   = !slot_q[0];
    last_slot = (slot_q == 4'd14);
    // A delayed ID change takes effect at the next even slot, which for
    // slot 14 is byte 0 of the following frame.
    eff_id_d  = (is_even && dly_v_q) ? dly_id_q : cur_id_q;
    is_idchg  = is_even && slot_byte[0];
    data_d    = is_even ? {slot_byte[7:1], aux_bit} : slot_byte;
    emit_d    = !is_idchg && (eff_id_d != 7'h00) && (eff_id_d != 7'h7F);
    // Pending frame is consumed when idle or when the working frame finishes.
    pend_take = !stall && pend_v_q &&
                ((state_q == S_IDLE) || ((state_q == S_DECODE) && last_slot));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      slot_q   <= 4'd0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      work_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      cur_id_q <= 7'h00;
      dly_id_q <= 7'h00;
      dly_v_q  <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= 8'h00;
      id_q     <= 7'h00;
      drop_q   <= '0;
    end else begin
      sync1_q <= PkAvail;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;

      // A frame arriving as the pending slot empties replaces it, no drop.
      if (frame_evt && (!pend_v_q || pend_take)) begin
        pend_q   <= Packet;
        pend_v_q <= 1'b1;
      end else if (pend_take) begin
        pend_v_q <= 1'b0;
      end else if (frame_evt && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end

      if (!stall) begin
        case (state_q)
          S_IDLE: begin
            valid_q <= 1'b0;
            if (pend_v_q) begin
              work_q  <= pend_q;
              slot_q  <= 4'd0;
              state_q <= S_DECODE;
            end
          end
          S_DECODE: begin
            valid_q <= emit_d;
            if (emit_d) begin
              out_q <= data_d;
              id_q  <= eff_id_d;
            end
            if (is_idchg) begin
              if (aux_bit) begin
                cur_id_q <= eff_id_d;
                dly_id_q <= slot_byte[7:1];
                dly_v_q  <= 1'b1;
              end else begin
                cur_id_q <= slot_byte[7:1];
                dly_v_q  <= 1'b0;
              end
            end else if (is_even) begin
              cur_id_q <= eff_id_d;
              dly_v_q  <= 1'b0;
            end
            if (last_slot) begin
              if (pend_v_q) begin
                work_q <= pend_q;
                slot_q <= 4'd0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              slot_q <= slot_q + 4'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign byteValid = valid_q;
  assign byteOut   = out_q;
  assign byteId    = id_q;
  assign dropCount = drop_q;

endmodule
